// File: rtl/averager_pkg.sv
`default_nettype none
// ============================================================================
// Module   : averager_pkg
// Brief    : Shared sequencer state encoding and default widths.
// Revision : 1.0 - initial release
// ============================================================================
package averager_pkg;

    localparam int c_WIDTH_DEFAULT     = 8;
    localparam int c_TIMEOUT_W_DEFAULT = 24;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_RUN    = 3'd2,
        ST_FINISH = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/averager_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : averager_sequencer_if
// Brief    : Control, config and averager-side signals of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface averager_sequencer_if
    import averager_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
);
    localparam int c_NW = 32 - WIDTH;

    logic             start;
    logic             abort;
    logic             ack;
    logic [WIDTH-1:0] cfg_period;
    logic [WIDTH-1:0] cfg_threshold;
    logic [c_NW-1:0]  cfg_n_target;
    logic [c_NW-1:0]  n_avg;
    logic             ready;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] threshold;
    logic             restart;
    logic             avg_on;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, abort, ack, cfg_period, cfg_threshold, cfg_n_target,
               n_avg, ready,
        input  period, threshold, restart, avg_on, busy, done, err
    );

    modport slave (
        input  start, abort, ack, cfg_period, cfg_threshold, cfg_n_target,
               n_avg, ready,
        output period, threshold, restart, avg_on, busy, done, err
    );

endinterface
`default_nettype wire

// File: rtl/averager_sequencer_stall_timer.sv
`default_nettype none
// ============================================================================
// Module   : averager_sequencer_stall_timer
// Brief    : Saturating stall counter, cleared whenever the watched value moves.
// Revision : 1.0 - initial release
// ============================================================================
module averager_sequencer_stall_timer #(
    parameter int TIMEOUT_W = 24,
    parameter int VALUE_W   = 24
) (
    input  wire logic               clk,
    input  wire logic               resetn,
    input  wire logic               i_clear,
    input  wire logic               i_enable,
    input  wire logic [VALUE_W-1:0] i_value,
    output logic                    o_terminal
);

    logic [VALUE_W-1:0]   r_prev;
    logic [TIMEOUT_W-1:0] r_count;
    logic                 w_changed;

    assign w_changed  = (i_value != r_prev);
    assign o_terminal = &r_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prev  <= '0;
            r_count <= '0;
        end else begin
            r_prev <= i_value;
            if (i_clear || w_changed) begin
                r_count <= '0;
            end else if (i_enable && !o_terminal) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/averager_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : averager_sequencer
// Brief    : Launches, monitors and terminates averager acquisitions.
// Revision : 1.0 - initial release
// ============================================================================
module averager_sequencer
    import averager_pkg::*;
#(
    parameter int WIDTH     = c_WIDTH_DEFAULT,
    parameter int TIMEOUT_W = c_TIMEOUT_W_DEFAULT
) (
    input  wire logic clk,
    input  wire logic resetn,
    averager_sequencer_if.slave bus
);

    localparam int c_NW = 32 - WIDTH;

    state_t           r_state;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_threshold;
    logic [c_NW-1:0]  r_target;
    logic             r_restart;
    logic             r_avg_on;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_ready_prev;

    logic             w_launch;
    logic             w_target_hit;
    logic             w_ready_rise;
    logic             w_timeout;
    logic [c_NW-1:0]  w_cfg_target;

    // A request for zero averages still collects one.
    assign w_cfg_target = (bus.cfg_n_target == '0) ? {{(c_NW-1){1'b0}}, 1'b1}
                                                   : bus.cfg_n_target;
    assign w_launch     = bus.start && (r_state inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign w_target_hit = bus.ready && (bus.n_avg >= r_target);
    assign w_ready_rise = bus.ready && !r_ready_prev;

    averager_sequencer_stall_timer #(
        .TIMEOUT_W (TIMEOUT_W),
        .VALUE_W   (c_NW)
    ) u_stall_timer (
        .clk        (clk),
        .resetn     (resetn),
        .i_clear    (r_state == ST_ARM),
        .i_enable   ((r_state == ST_RUN) || (r_state == ST_FINISH)),
        .i_value    (bus.n_avg),
        .o_terminal (w_timeout)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_period     <= '0;
            r_threshold  <= '0;
            r_target     <= {{(c_NW-1){1'b0}}, 1'b1};
            r_restart    <= 1'b0;
            r_avg_on     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_ready_prev <= 1'b0;
        end else begin
            r_ready_prev <= bus.ready;
            r_restart    <= 1'b0;
            if (w_launch) begin
                // Launch wins over ack when both arrive in DONE/ERROR.
                r_period    <= bus.cfg_period;
                r_threshold <= bus.cfg_threshold;
                r_target    <= w_cfg_target;
                r_state     <= ST_ARM;
                r_restart   <= 1'b1;
                r_avg_on    <= 1'b1;
                r_busy      <= 1'b1;
                r_done      <= 1'b0;
                r_err       <= 1'b0;
            end else begin
                case (r_state)
                    ST_ARM, ST_RUN, ST_FINISH: begin
                        if (bus.abort) begin
                            r_state  <= ST_IDLE;
                            r_avg_on <= 1'b0;
                            r_busy   <= 1'b0;
                        end else if (r_state == ST_ARM) begin
                            r_state <= ST_RUN;
                        end else if (w_timeout) begin
                            r_state  <= ST_ERROR;
                            r_avg_on <= 1'b0;
                            r_busy   <= 1'b0;
                            r_err    <= 1'b1;
                        end else if (r_state == ST_RUN && w_target_hit) begin
                            r_state  <= ST_FINISH;
                            r_avg_on <= 1'b0;
                        end else if (r_state == ST_FINISH && w_ready_rise) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    ST_DONE, ST_ERROR: begin
                        if (bus.ack) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b0;
                            r_err   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_avg_on <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.period    = r_period;
    assign bus.threshold = r_threshold;
    assign bus.restart   = r_restart;
    assign bus.avg_on    = r_avg_on;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_averager_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_averager_sequencer
// Brief    : Directed self-checking bench for averager_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_averager_sequencer;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    averager_sequencer_if #(.WIDTH(8)) bus ();

    averager_sequencer #(
        .WIDTH     (8),
        .TIMEOUT_W (12)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] p, input logic [7:0] t, input logic [23:0] n);
        bus.cfg_period    = p;
        bus.cfg_threshold = t;
        bus.cfg_n_target  = n;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.start = 0; bus.abort = 0; bus.ack = 0; bus.ready = 0;
        bus.cfg_period = 0; bus.cfg_threshold = 0; bus.cfg_n_target = 0; bus.n_avg = 0;
        tick(); tick();
        n_checks++;
        if ({bus.period, bus.threshold} !== 16'h0) begin
            n_fail++; $display("FAIL reset_cfg: got %h expected 0000", {bus.period, bus.threshold});
        end
        n_checks++;
        if ({bus.restart, bus.avg_on, bus.busy, bus.done, bus.err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_status: got %b expected 00000",
                               {bus.restart, bus.avg_on, bus.busy, bus.done, bus.err});
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bus.n_avg = 0; bus.ready = 0;
        tick();
        launch(8'd255, 8'd250, 24'd4);
        n_checks++;
        if ({bus.restart, bus.busy, bus.avg_on} !== 3'b111) begin
            n_fail++; $display("FAIL basic_arm: got restart/busy/avg_on %b expected 111",
                               {bus.restart, bus.busy, bus.avg_on});
        end
        n_checks++;
        if ({bus.period, bus.threshold} !== {8'd255, 8'd250}) begin
            n_fail++; $display("FAIL basic_cfg: got %0d/%0d expected 255/250", bus.period, bus.threshold);
        end
        tick();
        n_checks++;
        if ({bus.restart, bus.avg_on} !== 2'b01) begin
            n_fail++; $display("FAIL basic_restart_width: got restart/avg_on %b expected 01",
                               {bus.restart, bus.avg_on});
        end
        for (int n = 1; n <= 3; n++) begin
            bus.n_avg = 24'(n); bus.ready = 1; tick();
            bus.ready = 0; tick();
        end
        n_checks++;
        if ({bus.avg_on, bus.busy, bus.done} !== 3'b110) begin
            n_fail++; $display("FAIL basic_below_target: got avg_on/busy/done %b expected 110",
                               {bus.avg_on, bus.busy, bus.done});
        end
        bus.n_avg = 4; bus.ready = 1; tick();
        n_checks++;
        if ({bus.avg_on, bus.busy, bus.done} !== 3'b010) begin
            n_fail++; $display("FAIL basic_finish: got avg_on/busy/done %b expected 010",
                               {bus.avg_on, bus.busy, bus.done});
        end
        bus.ready = 0; tick();
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL basic_no_early_done: got %b expected 0", bus.done);
        end
        bus.ready = 1; tick();
        bus.ready = 0;
        n_checks++;
        if ({bus.done, bus.busy, bus.avg_on} !== 3'b100) begin
            n_fail++; $display("FAIL basic_done: got done/busy/avg_on %b expected 100",
                               {bus.done, bus.busy, bus.avg_on});
        end
        bus.ack = 1; tick(); bus.ack = 0;
        n_checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            n_fail++; $display("FAIL basic_ack: got done/busy %b expected 00", {bus.done, bus.busy});
        end
    endtask

    task automatic test_target_zero();
        bus.n_avg = 0; bus.ready = 0;
        tick();
        launch(8'd10, 8'd20, 24'd0);
        tick();
        bus.ready = 1; tick();
        n_checks++;
        if (bus.avg_on !== 1'b1) begin
            n_fail++; $display("FAIL tz_hold_at_zero: got avg_on %b expected 1", bus.avg_on);
        end
        bus.ready = 0; bus.n_avg = 1; tick();
        bus.ready = 1; tick();
        n_checks++;
        if ({bus.avg_on, bus.busy} !== 2'b01) begin
            n_fail++; $display("FAIL tz_finish: got avg_on/busy %b expected 01", {bus.avg_on, bus.busy});
        end
        bus.ready = 0; tick();
        bus.ready = 1; tick(); bus.ready = 0;
        n_checks++;
        if (bus.done !== 1'b1) begin
            n_fail++; $display("FAIL tz_done: got %b expected 1", bus.done);
        end
        bus.ack = 1; tick(); bus.ack = 0;
    endtask

    task automatic test_back_to_back();
        bus.n_avg = 0; bus.ready = 0;
        tick();
        launch(8'h40, 8'h41, 24'd1);
        tick();
        bus.start = 1; bus.cfg_period = 8'h99; tick(); bus.start = 0;
        n_checks++;
        if ({bus.restart, bus.busy, bus.period} !== {2'b01, 8'h40}) begin
            n_fail++; $display("FAIL b2b_start_ignored: got restart/busy %b period %h expected 01 40",
                               {bus.restart, bus.busy}, bus.period);
        end
        bus.n_avg = 1; bus.ready = 1; tick();
        bus.ready = 0; tick();
        bus.ready = 1; tick(); bus.ready = 0;
        n_checks++;
        if (bus.done !== 1'b1) begin
            n_fail++; $display("FAIL b2b_done: got %b expected 1", bus.done);
        end
        bus.start = 1; bus.ack = 1; bus.cfg_period = 8'h33; tick();
        bus.start = 0; bus.ack = 0;
        n_checks++;
        if ({bus.restart, bus.busy, bus.done, bus.period} !== {3'b110, 8'h33}) begin
            n_fail++; $display("FAIL b2b_start_wins: got restart/busy/done %b period %h expected 110 33",
                               {bus.restart, bus.busy, bus.done}, bus.period);
        end
        bus.abort = 1; tick(); bus.abort = 0;
        n_checks++;
        if ({bus.busy, bus.avg_on, bus.restart} !== 3'b000) begin
            n_fail++; $display("FAIL b2b_abort_arm: got busy/avg_on/restart %b expected 000",
                               {bus.busy, bus.avg_on, bus.restart});
        end
    endtask

    task automatic test_abort();
        bus.n_avg = 0; bus.ready = 0;
        tick();
        launch(8'hA5, 8'h05, 24'd3);
        tick();
        bus.cfg_period = 8'h11; tick();
        n_checks++;
        if (bus.period !== 8'hA5) begin
            n_fail++; $display("FAIL abort_cfg_frozen: got %h expected a5", bus.period);
        end
        bus.abort = 1; bus.start = 1; tick();
        bus.abort = 0; bus.start = 0;
        n_checks++;
        if ({bus.busy, bus.done, bus.err, bus.restart, bus.avg_on} !== 5'b0) begin
            n_fail++; $display("FAIL abort_idle: got busy/done/err/restart/avg_on %b expected 00000",
                               {bus.busy, bus.done, bus.err, bus.restart, bus.avg_on});
        end
        tick();
        n_checks++;
        if ({bus.restart, bus.busy} !== 2'b00) begin
            n_fail++; $display("FAIL abort_no_restart: got restart/busy %b expected 00",
                               {bus.restart, bus.busy});
        end
    endtask

    task automatic test_timeout();
        int cycles;
        bus.n_avg = 0; bus.ready = 0;
        tick(); tick();
        launch(8'd1, 8'd2, 24'd4);
        tick();
        cycles = 0;
        while (bus.err !== 1'b1 && cycles < 5000) begin
            tick();
            cycles++;
        end
        // 4095 increments to reach all-ones, one more edge to enter ERROR.
        n_checks++;
        if (cycles < 4090 || cycles > 4100) begin
            n_fail++; $display("FAIL timeout_latency: got %0d cycles expected about 4096", cycles);
        end
        n_checks++;
        if ({bus.err, bus.avg_on, bus.busy, bus.done} !== 4'b1000) begin
            n_fail++; $display("FAIL timeout_state: got err/avg_on/busy/done %b expected 1000",
                               {bus.err, bus.avg_on, bus.busy, bus.done});
        end
        launch(8'd1, 8'd2, 24'd4);
        n_checks++;
        if ({bus.err, bus.restart, bus.busy} !== 3'b011) begin
            n_fail++; $display("FAIL timeout_restart: got err/restart/busy %b expected 011",
                               {bus.err, bus.restart, bus.busy});
        end
        bus.abort = 1; tick(); bus.abort = 0;
    endtask

    task automatic test_reset_mid();
        bus.n_avg = 0; bus.ready = 0;
        tick();
        launch(8'h7E, 8'h3C, 24'd2);
        tick();
        bus.n_avg = 2; bus.ready = 1; tick(); bus.ready = 0;
        n_checks++;
        if ({bus.avg_on, bus.busy} !== 2'b01) begin
            n_fail++; $display("FAIL rst_mid_in_finish: got avg_on/busy %b expected 01",
                               {bus.avg_on, bus.busy});
        end
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.period, bus.threshold, bus.restart, bus.avg_on, bus.busy, bus.done, bus.err} !== 21'b0) begin
            n_fail++; $display("FAIL rst_mid_async: got period %h thr %h status %b expected all zero",
                               bus.period, bus.threshold,
                               {bus.restart, bus.avg_on, bus.busy, bus.done, bus.err});
        end
        #2;
        resetn = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if ({bus.restart, bus.avg_on, bus.busy, bus.period} !== 11'b0) begin
            n_fail++; $display("FAIL rst_mid_quiet: got restart/avg_on/busy %b period %h expected 000 00",
                               {bus.restart, bus.avg_on, bus.busy}, bus.period);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_target_zero();
        test_back_to_back();
        test_abort();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/averager_sequencer.md
AVERAGER_SEQUENCER -- requirements
Module: averager_sequencer

Interface
REQ-001 Parameter: WIDTH, default 8, log2 of averager frame length; sets period/threshold width.
REQ-002 Parameter: TIMEOUT_W, default 24, width of the stall-timeout counter.
REQ-003 clk  in  1  single system clock; all logic rising-edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request to launch an acquisition.
REQ-006 abort  in  1  one-cycle request to cancel the current acquisition.
REQ-007 ack  in  1  clears done/err.
REQ-008 cfg_period  in  WIDTH  requested frame period.
REQ-009 cfg_threshold  in  WIDTH  requested trigger threshold.
REQ-010 cfg_n_target  in  32-WIDTH  number of averages to collect; 0 is treated as 1.
REQ-011 n_avg  in  32-WIDTH  average count reported by the averager.
REQ-012 ready  in  1  averager frame-ready flag.
REQ-013 period, threshold  out  WIDTH each  registered config to the averager.
REQ-014 restart  out  1  one-cycle restart pulse to the averager.
REQ-015 avg_on  out  1  averaging enable to the averager.
REQ-016 busy, done, err  out  1 each  status: acquisition running / target reached / stall timeout.

Function
REQ-017 FSM states SHALL be IDLE, ARM, RUN, FINISH, DONE, ERROR; one-hot or binary is implementer's choice.
REQ-018 IDLE: on start, latch cfg_period, cfg_threshold, max(cfg_n_target,1) into period, threshold, target; next state ARM.
REQ-019 ARM: restart=1 for exactly one cycle, avg_on=1; next state RUN unconditionally.
REQ-020 RUN: avg_on=1; when ready=1 and n_avg>=target in the same cycle -> FINISH.
REQ-021 FINISH: avg_on=0; on the next cycle where ready is 1 after having been 0 (rising edge) -> DONE.
REQ-022 DONE: done=1, busy=0, avg_on=0; ack -> IDLE; start -> re-latch config and go to ARM (done cleared same edge).
REQ-023 busy SHALL be 1 in ARM, RUN, FINISH only; done only in DONE; err only in ERROR.
REQ-024 Timeout counter (TIMEOUT_W bits): cleared on entering ARM and whenever n_avg differs from its previous-cycle value; increments in RUN/FINISH; at all-ones -> ERROR.
REQ-025 ERROR: err=1, avg_on=0; ack -> IDLE; start -> ARM (err cleared).
REQ-026 abort in ARM/RUN/FINISH -> IDLE next edge, avg_on=0, done and err stay 0, no restart issued.
REQ-027 abort with start same cycle: abort wins; start with ack same cycle in DONE/ERROR: start wins.
REQ-028 start while busy SHALL be ignored; cfg_* changes while busy SHALL NOT affect outputs.
REQ-029 n_avg comparison unsigned, full 32-WIDTH bits; no wrap handling beyond width.

Reset
REQ-030 On resetn low: state IDLE, period=0, threshold=0, restart=0, avg_on=0, busy=0, done=0, err=0, target=1, timeout counter=0.
REQ-031 Reset asserted mid-acquisition SHALL force the above immediately (asynchronous), with no restart pulse on release.

Structure
REQ-032 State encoding enum and TIMEOUT_W default SHALL live in a shared package averager_pkg.
REQ-033 One sub-module natural: stall_timer (counter with clear-on-change and terminal flag).
REQ-034 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification (WIDTH=8, TIMEOUT_W=12)
REQ-035 Cfg period=255, threshold=250, target=4, start -> restart high exactly 1 cycle 1 clk after start; busy=1; period/threshold outputs 255/250.
REQ-036 Model n_avg increments 0..4 with ready pulses -> FINISH at n_avg=4 & ready, avg_on drops, done=1 after next ready rise; ack -> done=0.
REQ-037 target=0 -> behaves as target=1: done after first ready with n_avg>=1.
REQ-038 Freeze n_avg in RUN -> err=1 after 4095 stall cycles, avg_on=0; start -> err=0, restart pulse.
REQ-039 abort and start same cycle during RUN -> IDLE, busy=0, done=0, no restart; cfg change during RUN leaves period output unchanged.
REQ-040 resetn low during FINISH -> all outputs zero same cycle, period=0; after release no activity until start.
